window_3x3_gen: RTL and testbench

- Raster-scan 3x3 window generator that feeds the edge-preserving filter bank (P1 weighted 3x3 filter and siblings) with nine neighbourhood pixels.
- Accepts one 8-bit pixel per valid cycle.
- Buffers the two previous image rows in line buffers and presents a registered 3x3 window with a valid strobe.
- Emits windows only where the full neighbourhood exists inside the frame: no padding, output image is (H-2)x(W-2).

---
 rtl/window_3x3_gen.sv | 122 ++++++++++++
 tb/tb_window_3x3_gen.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: raster-scan 3x3 neighbourhood generator built from two row line buffers.
// Latency: the window with pixel (r,c) as out9 is registered on the edge that accepts (r,c).
// Backpressure: none; a pixel is consumed on every edge where pixel_valid is high.
module window_3x3_gen #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pixel_in,
    input  logic              pixel_valid,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic [DATA_W-1:0] out3,
    output logic [DATA_W-1:0] out4,
    output logic [DATA_W-1:0] out5,
    output logic [DATA_W-1:0] out6,
    output logic [DATA_W-1:0] out7,
    output logic [DATA_W-1:0] out8,
    output logic [DATA_W-1:0] out9,
    output logic              window_valid,
    output logic              frame_done
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    // Raster position of the pixel being presented
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;

    // lb0 holds row r-1, lb1 holds row r-2, both indexed by column
    logic [DATA_W-1:0] r_lb0 [IMG_WIDTH];
    logic [DATA_W-1:0] r_lb1 [IMG_WIDTH];

    // Window registers, row-major: [0..2] top row, [3..5] middle, [6..8] bottom
    logic [DATA_W-1:0] r_win [9];
    logic              r_win_vld;
    logic              r_frame_done;

    logic [DATA_W-1:0] w_lb0_rd;
    logic [DATA_W-1:0] w_lb1_rd;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_full_nbhd;

    assign w_lb0_rd    = r_lb0[r_col];
    assign w_lb1_rd    = r_lb1[r_col];
    assign w_col_last  = (r_col == COL_LAST);
    assign w_row_last  = (r_row == ROW_LAST);
    // Two rows above and two columns to the left exist inside the frame
    assign w_full_nbhd = (r_row >= RW'(2)) && (r_col >= CW'(2));

    // Column/row counters advance only on accepted pixels and wrap at frame end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (pixel_valid) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Line buffers: plain RAM, no reset; read-before-write at the current column
    always_ff @(posedge clk) begin
        if (pixel_valid) begin
            r_lb1[r_col] <= w_lb0_rd;
            r_lb0[r_col] <= pixel_in;
        end
    end

    // Window shifts left by one column per accepted pixel and loads the new right column
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= '0;
            end
        end else if (pixel_valid) begin
            r_win[0] <= r_win[1];
            r_win[1] <= r_win[2];
            r_win[2] <= w_lb1_rd;
            r_win[3] <= r_win[4];
            r_win[4] <= r_win[5];
            r_win[5] <= w_lb0_rd;
            r_win[6] <= r_win[7];
            r_win[7] <= r_win[8];
            r_win[8] <= pixel_in;
        end
    end

    // Single-cycle strobes: valid window and end-of-frame, cleared on idle cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_vld    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_win_vld    <= pixel_valid && w_full_nbhd;
            r_frame_done <= pixel_valid && w_col_last && w_row_last;
        end
    end

    assign out1         = r_win[0];
    assign out2         = r_win[1];
    assign out3         = r_win[2];
    assign out4         = r_win[3];
    assign out5         = r_win[4];
    assign out6         = r_win[5];
    assign out7         = r_win[6];
    assign out8         = r_win[7];
    assign out9         = r_win[8];
    assign window_valid = r_win_vld;
    assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen: checks window_3x3_gen on an 8x6 frame against an image-array reference.
// Latency: outputs sampled 1 time unit after the accepting rising edge.
// Backpressure: none; idle cycles are injected randomly to exercise hold behaviour.
module tb_window_3x3_gen;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] pixel_in = '0;
    logic          pixel_valid = 1'b0;
    logic [DW-1:0] out1, out2, out3, out4, out5, out6, out7, out8, out9;
    logic          window_valid;
    logic          frame_done;

    logic [DW-1:0] o [9];

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] first_w [2][9];
    logic [DW-1:0] last_w  [9];

    window_3x3_gen #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .DATA_W     (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pixel_in     (pixel_in),
        .pixel_valid  (pixel_valid),
        .out1         (out1),
        .out2         (out2),
        .out3         (out3),
        .out4         (out4),
        .out5         (out5),
        .out6         (out6),
        .out7         (out7),
        .out8         (out8),
        .out9         (out9),
        .window_valid (window_valid),
        .frame_done   (frame_done)
    );

    assign o[0] = out1;
    assign o[1] = out2;
    assign o[2] = out3;
    assign o[3] = out4;
    assign o[4] = out5;
    assign o[5] = out6;
    assign o[6] = out7;
    assign o[7] = out8;
    assign o[8] = out9;

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic v, input logic [DW-1:0] p);
        @(negedge clk);
        pixel_valid = v;
        pixel_in    = p;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        pixel_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Streams nfr frames; expected windows are cut directly out of the stored image.
    task automatic run_stream(input int nfr, input bit gaps, input bit rnd,
                              input logic [DW-1:0] base0, input int stop_after,
                              output int nvalid);
        logic [DW-1:0] img   [H][W];
        logic [DW-1:0] exp_w [9];
        logic [DW-1:0] pix;
        logic [DW-1:0] base;
        bit            have_w;
        bit            exp_v;
        bit            exp_fd;
        bit            first_seen;
        int            r;
        int            c;
        nvalid = 0;
        have_w = 1'b0;
        for (int fr = 0; fr < nfr; fr++) begin
            base = DW'(int'(base0) + fr * 128);
            first_seen = 1'b0;
            for (int k = 0; k < H * W; k++) begin
                r = k / W;
                c = k % W;
                pix = rnd ? DW'($urandom) : DW'(int'(base) + r * 16 + c);
                img[r][c] = pix;
                if (gaps) begin
                    while ($urandom_range(0, 1) == 1) begin
                        drive(1'b0, DW'($urandom));
                        n_vec++;
                        if (window_valid !== 1'b0) begin
                            n_err++;
                            $display("FAIL idle_valid at frame %0d k=%0d: got %b want 0", fr, k, window_valid);
                        end
                        n_vec++;
                        if (frame_done !== 1'b0) begin
                            n_err++;
                            $display("FAIL idle_frame_done at frame %0d k=%0d: got %b want 0", fr, k, frame_done);
                        end
                        if (have_w) begin
                            for (int i = 0; i < 9; i++) begin
                                n_vec++;
                                if (o[i] !== exp_w[i]) begin
                                    n_err++;
                                    $display("FAIL idle_hold out%0d at frame %0d k=%0d: got %h want %h", i + 1, fr, k, o[i], exp_w[i]);
                                end
                            end
                        end
                    end
                end
                drive(1'b1, pix);
                exp_v  = (r >= 2) && (c >= 2);
                exp_fd = (k == H * W - 1);
                n_vec++;
                if (window_valid !== exp_v) begin
                    n_err++;
                    $display("FAIL window_valid at frame %0d (%0d,%0d): got %b want %b", fr, r, c, window_valid, exp_v);
                end
                n_vec++;
                if (frame_done !== exp_fd) begin
                    n_err++;
                    $display("FAIL frame_done at frame %0d (%0d,%0d): got %b want %b", fr, r, c, frame_done, exp_fd);
                end
                have_w = exp_v;
                if (exp_v) begin
                    nvalid++;
                    for (int i = 0; i < 9; i++) begin
                        exp_w[i] = img[r - 2 + i / 3][c - 2 + i % 3];
                        n_vec++;
                        if (o[i] !== exp_w[i]) begin
                            n_err++;
                            $display("FAIL window out%0d at frame %0d (%0d,%0d): got %h want %h", i + 1, fr, r, c, o[i], exp_w[i]);
                        end
                        if (!first_seen && fr < 2) first_w[fr][i] = o[i];
                        last_w[i] = o[i];
                    end
                    first_seen = 1'b1;
                end
                if (stop_after >= 0 && fr * H * W + k == stop_after) return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 9; i++) begin
            n_vec++;
            if (o[i] !== '0) begin
                n_err++;
                $display("FAIL reset out%0d: got %h want 00", i + 1, o[i]);
            end
        end
        n_vec++;
        if (window_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset window_valid: got %b want 0", window_valid);
        end
        n_vec++;
        if (frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset frame_done: got %b want 0", frame_done);
        end
        do_reset();
    endtask

    task automatic test_first_window();
        logic [DW-1:0] exp [9];
        exp = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
        for (int k = 0; k < 19; k++) begin
            drive(1'b1, DW'((k / W) * 16 + (k % W)));
            n_vec++;
            if (window_valid !== (k == 18)) begin
                n_err++;
                $display("FAIL first_window valid at pixel %0d: got %b want %b", k, window_valid, (k == 18));
            end
        end
        for (int i = 0; i < 9; i++) begin
            n_vec++;
            if (o[i] !== exp[i]) begin
                n_err++;
                $display("FAIL first_window out%0d: got %h want %h", i + 1, o[i], exp[i]);
            end
        end
    endtask

    task automatic test_full_frame();
        int nv;
        do_reset();
        run_stream(1, 1'b0, 1'b0, 8'h00, -1, nv);
        n_vec++;
        if (nv !== (H - 2) * (W - 2)) begin
            n_err++;
            $display("FAIL full_frame count: got %0d want %0d", nv, (H - 2) * (W - 2));
        end
        n_vec++;
        if (last_w[8] !== 8'h57) begin
            n_err++;
            $display("FAIL full_frame last out9: got %h want 57", last_w[8]);
        end
        n_vec++;
        if (last_w[0] !== 8'h35) begin
            n_err++;
            $display("FAIL full_frame last out1: got %h want 35", last_w[0]);
        end
        drive(1'b0, 8'h00);
        n_vec++;
        if (frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL full_frame frame_done stretch: got %b want 0", frame_done);
        end
        n_vec++;
        if (window_valid !== 1'b0) begin
            n_err++;
            $display("FAIL full_frame valid stretch: got %b want 0", window_valid);
        end
    endtask

    task automatic test_gapped();
        int nv;
        do_reset();
        run_stream(1, 1'b1, 1'b0, 8'h00, -1, nv);
        n_vec++;
        if (nv !== (H - 2) * (W - 2)) begin
            n_err++;
            $display("FAIL gapped count: got %0d want %0d", nv, (H - 2) * (W - 2));
        end
    endtask

    task automatic test_random_pixels();
        int nv;
        do_reset();
        run_stream(1, 1'b1, 1'b1, 8'h00, -1, nv);
        n_vec++;
        if (nv !== (H - 2) * (W - 2)) begin
            n_err++;
            $display("FAIL random_pixels count: got %0d want %0d", nv, (H - 2) * (W - 2));
        end
    endtask

    task automatic test_back_to_back();
        int nv;
        logic [DW-1:0] exp [9];
        exp = '{8'h80, 8'h81, 8'h82, 8'h90, 8'h91, 8'h92, 8'hA0, 8'hA1, 8'hA2};
        do_reset();
        run_stream(2, 1'b0, 1'b0, 8'h00, -1, nv);
        n_vec++;
        if (nv !== 2 * (H - 2) * (W - 2)) begin
            n_err++;
            $display("FAIL back_to_back count: got %0d want %0d", nv, 2 * (H - 2) * (W - 2));
        end
        for (int i = 0; i < 9; i++) begin
            n_vec++;
            if (first_w[1][i] !== exp[i]) begin
                n_err++;
                $display("FAIL back_to_back first window out%0d: got %h want %h", i + 1, first_w[1][i], exp[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int nv;
        do_reset();
        run_stream(1, 1'b0, 1'b0, 8'h00, 3 * W + 4, nv);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 9; i++) begin
            n_vec++;
            if (o[i] !== '0) begin
                n_err++;
                $display("FAIL mid_reset out%0d: got %h want 00", i + 1, o[i]);
            end
        end
        n_vec++;
        if (window_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset window_valid: got %b want 0", window_valid);
        end
        n_vec++;
        if (frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset frame_done: got %b want 0", frame_done);
        end
        do_reset();
        test_first_window();
    endtask

    initial begin
        test_reset();
        test_first_window();
        test_full_frame();
        test_gapped();
        test_random_pixels();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
